// File: rtl/pcr_cmd_pkg.sv
// Shared types for the pipe-cleaning robot command path: drive codes, gamepad
// bit positions, arbiter states and mode encoding.
package pcr_cmd_pkg;

    typedef enum logic [2:0] {
        CMD_STOP  = 3'd0,
        CMD_FWD   = 3'd1,
        CMD_BACK  = 3'd2,
        CMD_LEFT  = 3'd3,
        CMD_RIGHT = 3'd4,
        CMD_CLEAN = 3'd5,
        CMD_RSVD6 = 3'd6,
        CMD_RSVD7 = 3'd7
    } drive_cmd_e;

    localparam int unsigned BTN_UP    = 0;
    localparam int unsigned BTN_DOWN  = 1;
    localparam int unsigned BTN_LEFT  = 2;
    localparam int unsigned BTN_RIGHT = 3;
    localparam int unsigned BTN_A     = 4;
    localparam int unsigned BTN_B     = 5;
    localparam int unsigned BTN_C     = 6;
    localparam int unsigned BTN_X     = 7;
    localparam int unsigned BTN_Y     = 8;
    localparam int unsigned BTN_Z     = 9;
    localparam int unsigned BTN_START = 10;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE    = 3'd1,
        ST_BUSY     = 3'd2,
        ST_COOLDOWN = 3'd3,
        ST_FAULT    = 3'd4
    } arb_state_e;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_AUTO   = 1'b1
    } mode_e;

    typedef struct packed {
        logic       valid;
        drive_cmd_e cmd;
    } drive_req_t;

    // Level decode of the direction pad and A button into a drive request.
    function automatic drive_req_t manual_decode(input logic [4:0] b);
        drive_req_t r;
        r.valid = 1'b1;
        r.cmd   = CMD_STOP;
        case (b[3:0])
            4'b0001: r.cmd = CMD_FWD;
            4'b0010: r.cmd = CMD_BACK;
            4'b0100: r.cmd = CMD_LEFT;
            4'b1000: r.cmd = CMD_RIGHT;
            4'b0000: begin
                r.valid = b[BTN_A];
                r.cmd   = CMD_CLEAN;
            end
            default: r.valid = 1'b0;
        endcase
        return r;
    endfunction

    // Auto codes that actually move the actuator; STOP and reserved are dropped.
    function automatic logic auto_cmd_ok(input logic [2:0] c);
        return (c >= 3'(CMD_FWD)) && (c <= 3'(CMD_CLEAN));
    endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// Registers a gamepad vector once and reports which bits rose this cycle.
module btn_edge_detect #(
    parameter int unsigned W = 11
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] buttons,
    output logic [W-1:0] rise_c
);

    logic [W-1:0] prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) prev <= '0;
        else       prev <= buttons;
    end

    assign rise_c = buttons & ~prev;

endmodule

// File: rtl/robot_cmd_arbiter.sv
// Arbitrates the robot's drive/brush actuator between gamepad and autonomous sequencer.
// Optional feature macro: MANUAL_OVERRIDE_EN (direction pad pre-empts auto mode in IDLE).
module robot_cmd_arbiter
    import pcr_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES  = 1000,
    parameter int unsigned COOLDOWN_CYCLES = 4,
    parameter int unsigned BTN_W           = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [BTN_W-1:0] buttons,
    input  logic             auto_req_valid,
    input  logic [2:0]       auto_req_cmd,
    output logic             auto_req_ready,
    output logic             drive_cmd_valid,
    output logic [2:0]       drive_cmd,
    input  logic             drive_ready,
    input  logic             drive_done,
    output logic             mode,
    output logic             grant_src,
    output logic             busy,
    output logic             fault
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CD_W  = $clog2(COOLDOWN_CYCLES + 1);

    arb_state_e       state;
    logic             pending_toggle;
    logic [TMR_W-1:0] timer;
    logic [CD_W-1:0]  cd_cnt;
    logic [BTN_W-1:0] rise;
    drive_req_t       man_req;
    logic             override_c;
    logic             unused_bits;

    btn_edge_detect #(.W(BTN_W)) u_edge (
        .clk     (clk),
        .reset   (reset),
        .buttons (buttons),
        .rise_c  (rise)
    );

    assign man_req     = manual_decode(buttons[4:0]);
    assign unused_bits = ^{buttons, rise};

`ifdef MANUAL_OVERRIDE_EN
    assign override_c = (state == ST_IDLE) && (mode == MODE_AUTO) && (|buttons[3:0]);
`else
    assign override_c = 1'b0;
`endif

    // Auto handshake is only offered while idling in auto mode with no toggle queued.
    assign auto_req_ready = (state == ST_IDLE) && (mode == MODE_AUTO) && !pending_toggle
                            && !override_c && auto_req_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= ST_IDLE;
            pending_toggle  <= 1'b0;
            timer           <= '0;
            cd_cnt          <= '0;
            drive_cmd_valid <= 1'b0;
            drive_cmd       <= 3'd0;
            mode            <= MODE_MANUAL;
            grant_src       <= 1'b0;
            busy            <= 1'b0;
            fault           <= 1'b0;
        end else begin
            // Start rises queue one toggle; later branches clear it when consumed.
            if (rise[BTN_START] && (state != ST_FAULT)) pending_toggle <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (override_c) begin
                        mode           <= MODE_MANUAL;
                        pending_toggle <= 1'b0;
                    end else if (pending_toggle) begin
                        mode           <= ~mode;
                        pending_toggle <= 1'b0;
                    end else if ((mode == MODE_MANUAL) && man_req.valid) begin
                        drive_cmd       <= man_req.cmd;
                        grant_src       <= 1'b0;
                        drive_cmd_valid <= 1'b1;
                        busy            <= 1'b1;
                        state           <= ST_ISSUE;
                    end else if (auto_req_ready && auto_cmd_ok(auto_req_cmd)) begin
                        drive_cmd       <= auto_req_cmd;
                        grant_src       <= 1'b1;
                        drive_cmd_valid <= 1'b1;
                        busy            <= 1'b1;
                        state           <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (drive_ready) begin
                        drive_cmd_valid <= 1'b0;
                        timer           <= '0;
                        state           <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (drive_done) begin
                        cd_cnt <= '0;
                        state  <= ST_COOLDOWN;
                    end else if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                        fault <= 1'b1;
                        state <= ST_FAULT;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                ST_COOLDOWN: begin
                    if (cd_cnt == CD_W'(COOLDOWN_CYCLES - 1)) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        cd_cnt <= cd_cnt + CD_W'(1);
                    end
                end
                ST_FAULT: begin
                    if (rise[BTN_C]) begin
                        fault          <= 1'b0;
                        busy           <= 1'b0;
                        mode           <= MODE_MANUAL;
                        pending_toggle <= 1'b0;
                        state          <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_robot_cmd_arbiter.sv
// Bench for robot_cmd_arbiter: directed scenarios plus random traffic against a cycle model.
module tb_robot_cmd_arbiter;

    localparam int unsigned TIMEOUT  = 1000;
    localparam int unsigned COOLDOWN = 4;
    localparam int unsigned BW       = 11;

    logic          clk = 1'b0;
    logic          reset;
    logic [BW-1:0] buttons;
    logic          auto_req_valid;
    logic [2:0]    auto_req_cmd;
    logic          auto_req_ready;
    logic          drive_cmd_valid;
    logic [2:0]    drive_cmd;
    logic          drive_ready;
    logic          drive_done;
    logic          mode;
    logic          grant_src;
    logic          busy;
    logic          fault;

    always #5 clk = ~clk;

    robot_cmd_arbiter #(
        .TIMEOUT_CYCLES  (TIMEOUT),
        .COOLDOWN_CYCLES (COOLDOWN),
        .BTN_W           (BW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .buttons         (buttons),
        .auto_req_valid  (auto_req_valid),
        .auto_req_cmd    (auto_req_cmd),
        .auto_req_ready  (auto_req_ready),
        .drive_cmd_valid (drive_cmd_valid),
        .drive_cmd       (drive_cmd),
        .drive_ready     (drive_ready),
        .drive_done      (drive_done),
        .mode            (mode),
        .grant_src       (grant_src),
        .busy            (busy),
        .fault           (fault)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 offering, 2 waiting for done, 3 resting, 4 faulted.
    int         ph;
    logic       m_mode, m_pend, m_src;
    logic [2:0] m_cmd;
    int         m_age, m_rest;
    logic [10:0] m_prev;

    // Actuator behaviour driven by the bench.
    int ready_pct = 100;
    int done_dly  = 5;
    bit withhold  = 0;
    int done_cnt  = -1;

    function automatic int man_cmd(input logic [10:0] b);
        if ($countones(b[3:0]) == 1) begin
            for (int i = 0; i < 4; i++) if (b[i]) return i + 1;
        end
        if (b[3:0] == 4'd0 && b[4]) return 5;
        return -1;
    endfunction

    function automatic bit model_override(input logic [10:0] b);
`ifdef MANUAL_OVERRIDE_EN
        return (ph == 0) && m_mode && (b[3:0] != 4'd0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        ph = 0; m_mode = 0; m_pend = 0; m_src = 0; m_cmd = 0;
        m_age = 0; m_rest = 0; m_prev = '0; done_cnt = -1;
    endtask

    task automatic model_step(input logic [10:0] b, input logic av, input logic [2:0] acmd,
                              input logic dr, input logic dd);
        bit sr, cr, consume, ovr;
        int mc, old_ph;
        sr = b[10] && !m_prev[10];
        cr = b[6] && !m_prev[6];
        mc = man_cmd(b);
        ovr = model_override(b);
        consume = 0;
        old_ph = ph;
        case (ph)
            0: begin
                if (ovr) begin m_mode = 0; m_pend = 0; consume = 1; end
                else if (m_pend) begin m_mode = !m_mode; m_pend = 0; consume = 1; end
                else if (!m_mode && mc >= 0) begin m_cmd = 3'(mc); m_src = 0; ph = 1; end
                else if (m_mode && av && acmd >= 3'd1 && acmd <= 3'd5) begin
                    m_cmd = acmd; m_src = 1; ph = 1;
                end
            end
            1: if (dr) begin ph = 2; m_age = 0; end
            2: begin
                if (dd) begin ph = 3; m_rest = COOLDOWN; end
                else begin m_age++; if (m_age == TIMEOUT) ph = 4; end
            end
            3: begin m_rest--; if (m_rest == 0) ph = 0; end
            4: if (cr) begin ph = 0; m_mode = 0; m_pend = 0; consume = 1; end
            default: ph = 0;
        endcase
        if (sr && old_ph != 4 && !consume) m_pend = 1;
        m_prev = b;
    endtask

    // One clock: drive at negedge, compare outputs, then advance the model over the posedge.
    task automatic cycle(input logic [10:0] b, input logic av, input logic [2:0] acmd);
        logic dr, dd, exp_rdy;
        bit acc;
        @(negedge clk);
        dr = ($urandom_range(0, 99) < ready_pct);
        dd = (done_cnt == 0);
        buttons = b; auto_req_valid = av; auto_req_cmd = acmd;
        drive_ready = dr; drive_done = dd;
        #1;
        exp_rdy = (ph == 0) && m_mode && !m_pend && av && !model_override(b);
        check("ready", auto_req_ready, exp_rdy);
        check("valid", drive_cmd_valid, ph == 1);
        check("busy", busy, ph != 0);
        check("fault", fault, ph == 4);
        check("mode", mode, m_mode);
        check("grant_src", grant_src, m_src);
        if (ph == 1) check("drive_cmd", drive_cmd, m_cmd);
        acc = (ph == 1) && dr;
        model_step(b, av, acmd, dr, dd);
        if (acc) done_cnt = withhold ? -1 : done_dly;
        else if (done_cnt >= 0) done_cnt--;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(11'h000, 1'b0, 3'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, drive_cmd_valid, 0);
        check({tag, "_cmd"}, drive_cmd, 0);
        check({tag, "_ready"}, auto_req_ready, 0);
        check({tag, "_mode"}, mode, 0);
        check({tag, "_src"}, grant_src, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_fault"}, fault, 0);
    endtask

    initial begin
        logic [10:0] rb;
        reset = 1'b1; buttons = '0; auto_req_valid = 0; auto_req_cmd = 0;
        drive_ready = 0; drive_done = 0;
        model_reset();
        #12;
        check_all_zero("reset");
        @(negedge clk); reset = 1'b0;

        // Manual press with auto-repeat while held.
        ready_pct = 100; done_dly = 5; withhold = 0;
        cycle(11'h008, 0, 0);
        @(posedge clk); #1;
        check("press_valid", drive_cmd_valid, 1);
        check("press_cmd", drive_cmd, 4);
        for (int i = 0; i < 25; i++) cycle(11'h008, 0, 0);
        idle_cycles(15);

        // Start pressed while busy: mode flips only once back in IDLE.
        cycle(11'h001, 0, 0);
        cycle(11'h000, 0, 0);
        cycle(11'h400, 0, 0);
        cycle(11'h400, 0, 0);
        idle_cycles(15);
        for (int i = 0; i < 6; i++) cycle(11'h000, 1, 3'd5);
        idle_cycles(15);

        // Reserved auto code is consumed and dropped.
        for (int i = 0; i < 3; i++) cycle(11'h000, 1, 3'd7);
        cycle(11'h000, 1, 3'd0);
        idle_cycles(2);

        // Back to manual: conflicting pad, then CLEAN.
        cycle(11'h400, 0, 0);
        idle_cycles(2);
        for (int i = 0; i < 4; i++) cycle(11'h003, 0, 0);
        cycle(11'h010, 0, 0);
        idle_cycles(15);

        // Watchdog: done never arrives.
        withhold = 1;
        cycle(11'h001, 0, 0);
        idle_cycles(int'(TIMEOUT) + 5);
        check("wd_fault", fault, 1);
        cycle(11'h400, 0, 0);
        idle_cycles(3);
        cycle(11'h040, 0, 0);
        @(posedge clk); #1;
        check("wd_clear_fault", fault, 0);
        check("wd_clear_mode", mode, 0);
        withhold = 0;
        idle_cycles(3);

        // Backpressure then asynchronous reset while offering.
        ready_pct = 0;
        cycle(11'h002, 0, 0);
        idle_cycles(10);
        buttons = '0;
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        model_reset();
        @(negedge clk); reset = 1'b0;
        ready_pct = 100;
        idle_cycles(2);

        // Auto mode with a direction press and an auto request together.
        cycle(11'h400, 0, 0);
        idle_cycles(2);
        cycle(11'h004, 1, 3'd5);
        cycle(11'h004, 0, 3'd0);
        idle_cycles(15);

        // Random traffic.
        rb = '0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 9) < 3) begin
                case ($urandom_range(0, 9))
                    0, 1, 2: rb = '0;
                    3, 4:    rb = 11'(1 << $urandom_range(0, 3));
                    5:       rb = 11'h010;
                    6:       rb = 11'(1 << $urandom_range(0, 10));
                    7:       rb = 11'($urandom_range(0, 2047));
                    8:       rb = 11'h400;
                    default: rb = 11'h040;
                endcase
            end
            if (n % 50 == 0) begin
                ready_pct = $urandom_range(20, 100);
                done_dly  = $urandom_range(0, 8);
            end
            cycle(rb, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/robot_cmd_arbiter.md
Name: robot_cmd_arbiter

Overview:
- Arbitrates the pipe-cleaning robot's single drive/brush actuator between two requesters.
  - Manual: the 11-bit decoded gamepad vector from the controller block.
  - Auto: the autonomous navigation sequencer.
- Handles mode switching (manual/auto) on the Start button.
- Issues one command at a time to the actuator using valid/ready, then waits for the done pulse.
- Enforces a post-command cooldown and a completion watchdog that latches a fault.

Parameters:
TIMEOUT_CYCLES, 1000, max cycles in BUSY waiting for drive_done before FAULT
COOLDOWN_CYCLES, 4, idle gap after each completed command (>=1)
BTN_W, 11, width of the button vector

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
buttons  in  BTN_W  controller vector; [0]up [1]down [2]left [3]right [4]A [5]B [6]C [7]X [8]Y [9]Z [10]start; 1=pressed
auto_req_valid  in  1  auto requester has a command
auto_req_cmd  in  3  auto command code
auto_req_ready  out  1  auto command accepted this cycle
drive_cmd_valid  out  1  command offered to actuator
drive_cmd  out  3  command code: 0 STOP, 1 FWD, 2 BACK, 3 LEFT, 4 RIGHT, 5 CLEAN, 6/7 reserved
drive_ready  in  1  actuator accepts command
drive_done  in  1  single-cycle completion pulse
mode  out  1  0 manual, 1 auto
grant_src  out  1  source of the current command (0 manual, 1 auto)
busy  out  1  state != IDLE
fault  out  1  watchdog fault latched

Behaviour:
- Reset values:
  - Outputs: all 0.
  - Internal: state IDLE, mode manual, pending_toggle 0, prev buttons 0.
  - Reset asserted mid-operation drops drive_cmd_valid immediately; any command in flight is abandoned.
- Edge detection: buttons registered once; rise = buttons & ~prev.
- Start rise sets pending_toggle, in any state except FAULT; multiple rises collapse into one toggle.
- Manual decode (level, combinational on buttons):
  - Exactly one of [3:0] set -> FWD/BACK/LEFT/RIGHT respectively.
  - No direction bit set and A set -> CLEAN.
  - Anything else -> no request.
- States:
  - IDLE:
    - If pending_toggle: flip mode, clear pending_toggle, issue nothing this cycle.
    - Else if mode=0 and manual request: latch cmd, grant_src=0, go ISSUE.
    - Else if mode=1 and auto_req_valid: auto_req_ready=1 (combinational, this state only) and latch cmd.
      - Codes 0, 6 and 7 are consumed and dropped; stay IDLE.
      - Other codes: grant_src=1, go ISSUE.
  - ISSUE:
    - drive_cmd_valid=1; drive_cmd held stable until drive_valid&drive_ready, then go BUSY with timer=0.
    - drive_done in ISSUE is ignored.
  - BUSY:
    - Timer increments each cycle.
    - drive_done -> COOLDOWN.
    - Timer == TIMEOUT_CYCLES-1 without done -> FAULT.
    - done and timeout in the same cycle: done wins.
  - COOLDOWN: COOLDOWN_CYCLES cycles, then IDLE. A held manual button re-issues after the cooldown (auto-repeat).
  - FAULT:
    - fault=1, no valid, no ready.
    - Exit on C rise -> IDLE: fault=0, mode forced 0, pending_toggle cleared.
- Latency:
  - Manual press to drive_cmd_valid: 1 cycle, when in IDLE.
  - Auto handshake to drive_cmd_valid: next cycle.
- auto_req_ready is never asserted outside IDLE or while mode=0.

Optional Feature:
MANUAL_OVERRIDE_EN
- Defined: in IDLE with mode=1, any of buttons[3:0] set forces mode=0 that cycle.
  - auto_req_ready is held 0 that cycle and pending_toggle is cleared.
  - The manual command issues on the following cycle.
- Undefined: buttons other than start and C are ignored in auto mode.

Decomposition:
- Package pcr_cmd_pkg holds:
  - command code constants/enum;
  - button bit index constants;
  - arbiter state enum;
  - mode encoding.
- One sub-module: btn_edge_detect (BTN_W-wide register plus rise vector, async reset), reusable by other gamepad consumers.

Test Plan:
- Manual press: reset, hold buttons=0x008 (right), drive_ready=1, done 5 cycles after accept.
  - Expect drive_cmd=4 one cycle after press.
  - Expect BUSY, then 4 cooldown cycles, then re-issue of cmd 4 while held.
- Mode toggle during BUSY: pulse start (bit10) during BUSY.
  - Expect mode unchanged until IDLE, then mode=1.
  - Expect auto_req_valid with cmd=5 to be accepted (auto_req_ready=1) and drive_cmd=5, grant_src=1.
- Invalid and conflicting requests:
  - Auto cmd=7: ready=1, no drive_cmd_valid, stays IDLE.
  - Manual buttons=0x003 (up+down): no issue.
  - Manual buttons=0x010 (A): CLEAN (5).
- Watchdog: accept a command, withhold drive_done.
  - Expect fault=1 exactly TIMEOUT_CYCLES cycles after entering BUSY.
  - Start rise ignored; C rise clears fault, mode=0.
- Backpressure and reset: drive_ready=0 for 10 cycles; drive_cmd stays constant and valid.
  - Assert reset mid-ISSUE: valid drops asynchronously, all outputs 0.
- With MANUAL_OVERRIDE_EN: mode=1, auto_req_valid=1 and buttons=0x004 in the same cycle.
  - Expect mode=0, auto_req_ready=0, drive_cmd=3 the next cycle.
